// File: rtl/data_mem_lsu_pkg.sv
// Shared constants and lane/extension helpers for the RV32I data memory LSU.
package data_mem_lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Access size lives in f3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the narrow store operand so every enabled lane sees it.
  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] word);
    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            b;
    logic [15:0]           h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'h0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lsu_bram32_be.sv
// Word array with byte-enable write, registered read and asynchronous debug read.
module bram32_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [31:0]      dbg_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are never reset; only enabled lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read samples pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/data_mem_lsu.sv
// RV32I byte-addressable data memory with load/store unit, init loader and debug port.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            func3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  misaligned,
  input  logic                  init_mode,
  input  logic                  init_valid,
  output logic                  init_ready,
  input  logic [ADDR_WIDTH-3:0] init_addr,
  input  logic [31:0]           init_data,
  output logic [ADDR_WIDTH-2:0] init_count,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W = ADDR_WIDTH - 1;

  logic [IDX_W-1:0] core_idx;
  logic [1:0]       core_off;
  logic             core_en;
  logic             mis_c;
  logic             ld_ok;
  logic             st_ok;
  logic             init_fire;
  logic             init_rise;
  logic             init_mode_q;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_q;
  logic [1:0]       ld_off;
  logic [2:0]       ld_f3;
  logic             unused_bits;

  assign core_idx  = addr[ADDR_WIDTH-1:2];
  assign core_off  = addr[1:0];
  assign core_en   = ~init_mode & ~rst;
  assign mis_c     = is_misaligned(func3, core_off);
  assign ld_ok     = core_en & mem_read & load_legal(func3) & ~mis_c;
  assign st_ok     = core_en & mem_write & store_legal(func3) & ~mis_c;
  assign init_ready = init_mode & ~rst;
  assign init_fire  = init_valid & init_ready;
  assign init_rise  = init_mode & ~init_mode_q;
  assign unused_bits = ^{addr[31:ADDR_WIDTH], debug_addr[1:0]};

  // Write-port mux: the loader owns the port whenever init_mode is high.
  always_comb begin
    ram_we    = 4'b0000;
    ram_waddr = core_idx;
    ram_wdata = store_lanes(func3, wdata);
    if (init_mode) begin
      ram_we    = init_fire ? 4'b1111 : 4'b0000;
      ram_waddr = init_addr;
      ram_wdata = init_data;
    end else if (st_ok) begin
      ram_we    = byte_en(func3, core_off);
    end
  end

  bram32_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .re       (ld_ok),
    .raddr    (core_idx),
    .rdata    (ram_q),
    .dbg_addr (debug_addr[ADDR_WIDTH-1:2]),
    .dbg_data (debug_data)
  );

  // Load context and status pulses; all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_off      <= 2'b00;
      ld_f3       <= 3'b000;
      rvalid      <= 1'b0;
      misaligned  <= 1'b0;
      init_mode_q <= 1'b0;
    end else begin
      rvalid      <= ld_ok;
      misaligned  <= core_en & mis_c &
                     ((mem_read & load_legal(func3)) | (mem_write & store_legal(func3)));
      init_mode_q <= init_mode;
      if (ld_ok) begin
        ld_off <= core_off;
        ld_f3  <= func3;
      end
    end
  end

  // Accepted-word counter restarts on entry to init mode and saturates at full depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_count <= '0;
    end else if (init_rise || init_fire) begin
      if (init_fire && (init_rise || init_count < CNT_W'(DEPTH_WORDS)))
        init_count <= (init_rise ? CNT_W'(0) : init_count) + CNT_W'(1);
      else if (init_rise)
        init_count <= '0;
    end
  end

  assign rdata = load_extend(ld_f3, ld_off, ram_q);

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized bench for data_mem_lsu checked every cycle against a byte-array model.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;
  logic        init_mode = 1'b0;
  logic        init_valid = 1'b0;
  logic        init_ready;
  logic [9:0]  init_addr = 10'h0;
  logic [31:0] init_data = 32'h0;
  logic [10:0] init_count;
  logic [11:0] debug_addr = 12'h0;
  logic [31:0] debug_data;

  int total = 0;
  int bad = 0;

  data_mem_lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .misaligned(misaligned), .init_mode(init_mode), .init_valid(init_valid),
    .init_ready(init_ready), .init_addr(init_addr), .init_data(init_data),
    .init_count(init_count), .debug_addr(debug_addr), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  // Reference model: flat byte array plus expected output values.
  logic [7:0]  mm [4096];
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_rvalid = 1'b0;
  bit          exp_mis = 1'b0;
  int          exp_cnt = 0;
  bit          prev_mode = 1'b0;
  bit          mem_known = 1'b0;

  function automatic logic [31:0] model_word(input logic [11:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int          m_n;
  int          m_a;
  bit          m_rise;
  logic [31:0] m_val;

  always @(posedge clk) begin
    if (rst) begin
      exp_rvalid = 1'b0; exp_mis = 1'b0; exp_rdata = 32'h0; exp_cnt = 0; prev_mode = 1'b0;
    end else begin
      m_rise = init_mode && !prev_mode;
      prev_mode = init_mode;
      exp_rvalid = 1'b0;
      exp_mis = 1'b0;
      if (init_mode) begin
        if (m_rise) exp_cnt = 0;
        if (init_valid) begin
          for (int k = 0; k < 4; k++) mm[int'(init_addr) * 4 + k] = init_data[8*k +: 8];
          if (exp_cnt < 1024) exp_cnt++;
        end
      end else begin
        m_n = 1 << func3[1:0];
        m_a = int'(addr[11:0]);
        if (mem_read && func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          if (m_a % m_n != 0) exp_mis = 1'b1;
          else begin
            m_val = 32'h0;
            for (int k = 0; k < m_n; k++) m_val = m_val | (32'(mm[m_a + k]) << (8 * k));
            if (!func3[2] && m_n < 4 && m_val[8*m_n-1])
              m_val = m_val | ~((32'h1 << (8 * m_n)) - 32'h1);
            exp_rdata = m_val;
            exp_rvalid = 1'b1;
          end
        end
        if (mem_write && func3 < 3'd3) begin
          if (m_a % m_n != 0) exp_mis = 1'b1;
          else for (int k = 0; k < m_n; k++) mm[m_a + k] = wdata[8*k +: 8];
        end
      end
    end
  end

  always @(posedge rst) begin
    exp_rvalid = 1'b0; exp_mis = 1'b0; exp_rdata = 32'h0; exp_cnt = 0;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("misaligned", 32'(misaligned), 32'(exp_mis));
    chk("rdata", rdata, exp_rdata);
    chk("init_count", 32'(init_count), 32'(exp_cnt));
    chk("init_ready", 32'(init_ready), 32'(init_mode & ~rst));
    if (mem_known) chk("debug_data", debug_data, model_word(debug_addr));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic core(input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic init_word(input logic [9:0] idx, input logic [31:0] d);
    init_valid = 1'b1; init_addr = idx; init_data = d;
    step();
    init_valid = 1'b0;
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    debug_addr = a;
    #1;
    chk(name, debug_data, exp);
  endtask

  initial begin
    step();
    step();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_count", 32'(init_count), 32'h0);
    rst = 1'b0;
    step();

    // Fill the whole array through the loader with random gaps.
    init_mode = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      while ($urandom_range(3) == 0) step();
      init_word(10'(i), $urandom);
    end
    mem_known = 1'b1;
    chk("count_full", 32'(init_count), 32'd1024);
    init_word(10'd5, $urandom);
    init_word(10'd6, $urandom);
    chk("count_saturate", 32'(init_count), 32'd1024);

    init_mode = 1'b0;
    step();
    init_mode = 1'b1;
    init_word(10'd0, 32'h11111111);
    init_word(10'd1, 32'h22222222);
    init_word(10'd2, 32'h33333333);
    init_word(10'd3, 32'h44444444);
    chk("count_four", 32'(init_count), 32'd4);
    peek("init_word2", 12'h008, 32'h33333333);

    core(1'b0, 1'b1, 3'b010, 32'h0, 32'hFFFFFFFF);
    peek("init_blocks_core", 12'h000, 32'h11111111);
    init_mode = 1'b0;
    step();

    core(1'b0, 1'b1, 3'b010, 32'h0C, 32'hDEADBEEF);
    peek("sw_word", 12'h00C, 32'hDEADBEEF);
    core(1'b1, 1'b0, 3'b000, 32'h0D, 32'h0);
    chk("lb_data", rdata, 32'hFFFFFFBE);
    chk("lb_valid", 32'(rvalid), 32'h1);
    step();
    chk("rvalid_pulse", 32'(rvalid), 32'h0);
    chk("rdata_hold", rdata, 32'hFFFFFFBE);
    core(1'b1, 1'b0, 3'b100, 32'h0F, 32'h0);
    chk("lbu_data", rdata, 32'h000000DE);
    core(1'b1, 1'b0, 3'b001, 32'h0E, 32'h0);
    chk("lh_data", rdata, 32'hFFFFDEAD);
    core(1'b1, 1'b0, 3'b101, 32'h0C, 32'h0);
    chk("lhu_data", rdata, 32'h0000BEEF);
    core(1'b0, 1'b1, 3'b000, 32'h0D, 32'h12);
    peek("sb_merge", 12'h00C, 32'hDEAD12EF);

    core(1'b0, 1'b1, 3'b010, 32'h06, 32'hAAAAAAAA);
    chk("sw_mis", 32'(misaligned), 32'h1);
    peek("sw_mis_nowrite", 12'h004, 32'h22222222);
    core(1'b1, 1'b0, 3'b001, 32'h03, 32'h0);
    chk("lh_mis", 32'(misaligned), 32'h1);
    chk("lh_mis_novalid", 32'(rvalid), 32'h0);
    core(1'b1, 1'b0, 3'b111, 32'h00, 32'h0);
    chk("illegal_silent", 32'(misaligned), 32'h0);

    core(1'b0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D);
    peek("addr_wrap", 12'h000, 32'hCAFEF00D);
    core(1'b1, 1'b1, 3'b010, 32'h08, 32'h55555555);
    chk("rbw_old", rdata, 32'h33333333);
    peek("rbw_new", 12'h008, 32'h55555555);

    // Load whose pending result is cancelled by reset.
    debug_addr = 12'h000;
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_cancel_valid", 32'(rvalid), 32'h0);
    chk("rst_cancel_rdata", rdata, 32'h0);
    peek("rst_keeps_mem", 12'h000, 32'hCAFEF00D);
    step();
    rst = 1'b0;
    step();

    // Random traffic on a small window so collisions and reuse are frequent.
    for (int c = 0; c < 3000; c++) begin
      mem_read   = ($urandom_range(1) == 1);
      mem_write  = ($urandom_range(2) == 0);
      func3      = 3'($urandom_range(7));
      addr       = $urandom & 32'hFFFF_F03F;
      wdata      = $urandom;
      debug_addr = 12'($urandom & 32'h03F);
      init_valid = ($urandom_range(1) == 1);
      init_addr  = 10'($urandom_range(15));
      init_data  = $urandom;
      if ($urandom_range(49) == 0) init_mode = ~init_mode;
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0; init_mode = 1'b0; init_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
